// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer
//  Purpose  : Parallel-to-serial front end for serial sequence detectors.
//             Accepts WIDTH-bit words over valid/ready and shifts out one bit
//             per bit_en strobe. A one-word holding register lets back-to-back
//             words stream with no gap bits.
//  Options  : define SER_PARITY_EN to append an even-parity bit to each word.
//  Revision : 1.0  initial release
// ============================================================================
module bit_serializer #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   input  logic             bit_en,
   output logic             out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done
);

`ifdef SER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW = $clog2(NBITS + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [NBITS-1:0]   shreg, shreg_n;     // bits still to send, next one at [0]
   logic [WIDTH-1:0]   hold, hold_n;
   logic               hold_full, hold_full_n;
   logic               out_n, bit_valid_n;
   logic               load;
   logic [NBITS-1:0]   load_seq;           // hold reordered into transmit order

   // Reorder the held word so that element 0 is always the first bit on the wire.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_order
         if (MSB_FIRST) begin : g_msb
            assign load_seq[gi] = hold[WIDTH-1-gi];
         end else begin : g_lsb
            assign load_seq[gi] = hold[gi];
         end
      end
   endgenerate

`ifdef SER_PARITY_EN
   // Even parity travels after the last data bit.
   assign load_seq[WIDTH] = ^hold;
`endif

   // Ready is purely a function of the holding register, never of word_valid.
   assign word_ready = ~hold_full;
   assign busy       = (state == SHIFT) | hold_full;

   // Next-state, shifter, holding register and done strobe.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      shreg_n     = shreg;
      out_n       = out;
      bit_valid_n = bit_valid;
      hold_n      = hold;
      hold_full_n = hold_full;
      load        = 1'b0;
      done        = 1'b0;

      case (state)
         IDLE: begin
            if (hold_full) begin
               load = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_en) begin
               if (cnt == LAST_IDX) begin
                  done = 1'b1;
                  if (hold_full) begin
                     load = 1'b1;
                  end else begin
                     out_n       = IDLE_BIT;
                     bit_valid_n = 1'b0;
                     cnt_n       = '0;
                     state_n     = IDLE;
                  end
               end else begin
                  cnt_n   = cnt + CW'(1);
                  out_n   = shreg[0];
                  shreg_n = shreg >> 1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // A load only happens with hold_full set, so it never collides with an accept.
      if (load) begin
         out_n       = load_seq[0];
         shreg_n     = load_seq >> 1;
         cnt_n       = '0;
         bit_valid_n = 1'b1;
         hold_full_n = 1'b0;
         state_n     = SHIFT;
      end

      if (word_valid && !hold_full) begin
         hold_n      = word_in;
         hold_full_n = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         out       <= IDLE_BIT;
         bit_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         shreg     <= shreg_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         out       <= out_n;
         bit_valid <= bit_valid_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serializer
//  Purpose  : Self-checking bench for bit_serializer (WIDTH=4, both bit orders).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

   localparam int W = 4;
`ifdef SER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] word_in;
   logic         word_valid;
   logic         bit_en;
   logic         ready_m, out_m, bv_m, busy_m, done_m;
   logic         ready_l, out_l, bv_l, busy_l, done_l;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference stream: expected bits in wire order for both orderings,
   // plus a flag marking the final bit of each word.
   bit           q_m[$];
   bit           q_l[$];
   bit           q_last[$];
   logic [W-1:0] send_q[$];
   int           done_cyc[$];
   int           gaps;
   bit           saw_ready_low;

   typedef struct {
      logic [W-1:0] w;
      logic [4:0]   seq_m;   // [4] first on the wire, [0] = parity bit
      logic [4:0]   seq_l;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(ready_m), .bit_en(bit_en), .out(out_m), .bit_valid(bv_m),
      .busy(busy_m), .done(done_m));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(ready_l), .bit_en(bit_en), .out(out_l), .bit_valid(bv_l),
      .busy(busy_l), .done(done_l));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         q_m.push_back(w[W-1-i]);
         q_l.push_back(w[i]);
         q_last.push_back(1'b0);
      end
`ifdef SER_PARITY_EN
      q_m.push_back(^w);
      q_l.push_back(^w);
      q_last.push_back(1'b0);
`endif
      q_last[q_last.size()-1] = 1'b1;
   endfunction

   // One word from idle with bit_en held high; checks latency and every bit.
   task automatic run_vector(input vec_t v);
      word_in    = v.w;
      word_valid = 1'b1;
      bit_en     = 1'b1;
      #1;
      chk("vec_ready", ready_m, 1);
      tick();
      word_valid = 1'b0;
      word_in    = W'($urandom);
      chk("vec_latency_bv", bv_m, 0);
      chk("vec_busy_hold", busy_m, 1);
      tick();
      for (int k = 0; k < NB; k++) begin
         chk("vec_bit_m", out_m, v.seq_m[4-k]);
         chk("vec_bit_l", out_l, v.seq_l[4-k]);
         chk("vec_bv", bv_m, 1);
         chk("vec_done", done_m, (k == NB-1));
         tick();
      end
      chk("vec_end_bv", bv_m, 0);
      chk("vec_end_out", out_m, 0);
      chk("vec_end_ready", ready_m, 1);
      chk("vec_end_busy", busy_m, 0);
   endtask

   // Streams send_q through the DUTs; en_mode 0: always, 1: every 3rd, 2: random.
   task automatic run_stream(input int en_mode, input int vprob, input int budget);
      int  cyc = 0;
      bit  acc;
      bit  started = 1'b0;
      bit  lastb;
      gaps          = 0;
      saw_ready_low = 1'b0;
      done_cyc.delete();
      while ((send_q.size() > 0 || q_m.size() > 0) && cyc < budget) begin
         word_valid = (send_q.size() > 0) && ($urandom_range(99) < vprob);
         word_in    = (ready_m && word_valid) ? send_q[0] : W'($urandom);
         case (en_mode)
            0:       bit_en = 1'b1;
            1:       bit_en = (cyc % 3 == 2);
            default: bit_en = $urandom_range(1);
         endcase
         #1;
         if (!ready_m) saw_ready_low = 1'b1;
         if (bv_m) started = 1'b1;
         if (started && q_m.size() > 0 && !bv_m) gaps++;
         if (bv_m && bit_en) begin
            if (q_m.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_bit: got bit %0b expected none", out_m);
            end else begin
               lastb = q_last.pop_front();
               chk("stream_bit_m", out_m, q_m.pop_front());
               chk("stream_bit_l", out_l, q_l.pop_front());
               chk("stream_done_m", done_m, lastb);
               chk("stream_done_l", done_l, lastb);
               if (lastb) done_cyc.push_back(cyc);
            end
         end else begin
            chk("stream_nodone", done_m, 0);
         end
         acc = word_valid && ready_m;
         tick();
         cyc++;
         if (acc) push_word(send_q.pop_front());
      end
      word_valid = 1'b0;
      bit_en     = 1'b0;
      chk("stream_drained", (send_q.size() == 0 && q_m.size() == 0), 1);
      chk("stream_idle_bv", bv_m, 0);
      chk("stream_idle_busy", busy_m, 0);
   endtask

   initial begin
      vecs[0] = '{4'b1001, 5'b10010, 5'b10010};
      vecs[1] = '{4'b0001, 5'b00011, 5'b10001};
      vecs[2] = '{4'b1101, 5'b11011, 5'b10111};
      vecs[3] = '{4'b0110, 5'b01100, 5'b01100};
      vecs[4] = '{4'b1010, 5'b10100, 5'b01010};
      vecs[5] = '{4'b1011, 5'b10111, 5'b11011};
      vecs[6] = '{4'b1111, 5'b11110, 5'b11110};

      rst = 1'b1; word_valid = 1'b0; bit_en = 1'b0; word_in = '0;
      tick();
      tick();
      chk("rst_out", out_m, 0);
      chk("rst_bv", bv_m, 0);
      chk("rst_ready", ready_m, 1);
      chk("rst_busy", busy_m, 0);
      chk("rst_done", done_m, 0);
      rst = 1'b0;
      tick();

      // Single words from idle, both orders.
      for (int i = 0; i < 7; i++) run_vector(vecs[i]);

      // Back-to-back 1001 then 0011 with valid held: gapless, two dones NB apart.
      send_q.push_back(4'b1001);
      send_q.push_back(4'b0011);
      run_stream(0, 100, 200);
      chk("t2_gaps", gaps, 0);
      chk("t2_done_count", done_cyc.size(), 2);
      if (done_cyc.size() == 2) chk("t2_done_spacing", done_cyc[1] - done_cyc[0], NB);

      // Slow bit rate: bits held across stalls, second word waits in hold.
      send_q.push_back(4'b1010);
      send_q.push_back(4'b0110);
      run_stream(1, 100, 200);
      chk("t3_ready_low", saw_ready_low, 1);

      // Reset after the second bit of 1101 discards the word.
      word_in = 4'b1101; word_valid = 1'b1; bit_en = 1'b1;
      tick();
      word_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("t4_mid_bv", bv_m, 1);
      rst = 1'b1;
      #1;
      chk("t4_no_done", done_m, 0);
      tick();
      rst = 1'b0;
      chk("t4_out", out_m, 0);
      chk("t4_bv", bv_m, 0);
      chk("t4_ready", ready_m, 1);
      chk("t4_busy", busy_m, 0);
      chk("t4_done", done_m, 0);
      run_vector(vecs[2]);

      // Randomized traffic against the reference stream.
      for (int i = 0; i < 40; i++) send_q.push_back(W'($urandom));
      run_stream(2, 60, 4000);
      for (int i = 0; i < 20; i++) send_q.push_back(W'($urandom));
      run_stream(0, 85, 2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
